// File: rtl/game_seq_pkg.sv
// ---------------------------------------------------------------------------
// game_seq_pkg
// Shared definitions for the game round sequencer:
//   - game_state_t : FSM state encoding driven onto game_state
//   - ST_W         : width of the game_state output
//   - RIGHT/LEFT/UP/DOWN : sprite direction constants used by the datapath
// Optional feature macro: GAME_SEQ_PAUSE_EN adds the PAUSE state (encoding
// of the other states does not change).
// ---------------------------------------------------------------------------
package game_seq_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE        = 3'd0,
        ST_READY       = 3'd1,
        ST_PLAY        = 3'd2,
        ST_DYING       = 3'd3,
        ST_RESPAWN     = 3'd4,
        ST_LEVEL_CLEAR = 3'd5,
`ifdef GAME_SEQ_PAUSE_EN
        ST_GAME_OVER   = 3'd6,
        ST_PAUSE       = 3'd7
`else
        ST_GAME_OVER   = 3'd6
`endif
    } game_state_t;

    localparam logic [1:0] RIGHT = 2'd0;
    localparam logic [1:0] LEFT  = 2'd1;
    localparam logic [1:0] UP    = 2'd2;
    localparam logic [1:0] DOWN  = 2'd3;

endpackage

// File: rtl/game_round_sequencer_if.sv
// ---------------------------------------------------------------------------
// game_round_sequencer_if
// Bundles the game-event inputs and the control outputs of the sequencer.
//   master : the surrounding game logic (drives events, observes controls)
//   slave  : the sequencer itself
// Signals: frame_tick, start_btn, pacman_is_dead, food_eaten (events in);
//          pacman_move_en, ghost_move_en, sprite_reload, score_clear,
//          score_inc, lives, game_state, game_over (controls out).
// Optional feature macro: GAME_SEQ_PAUSE_EN adds pause_btn.
// ---------------------------------------------------------------------------
interface game_round_sequencer_if #(
    parameter int LIVES_W = 2
);
    import game_seq_pkg::*;

    logic               frame_tick;
    logic               start_btn;
    logic               pacman_is_dead;
    logic               food_eaten;
`ifdef GAME_SEQ_PAUSE_EN
    logic               pause_btn;
`endif
    logic               pacman_move_en;
    logic               ghost_move_en;
    logic               sprite_reload;
    logic               score_clear;
    logic               score_inc;
    logic [LIVES_W-1:0] lives;
    logic [ST_W-1:0]    game_state;
    logic               game_over;

`ifdef GAME_SEQ_PAUSE_EN
    modport master (
        output frame_tick, start_btn, pacman_is_dead, food_eaten, pause_btn,
        input  pacman_move_en, ghost_move_en, sprite_reload, score_clear,
               score_inc, lives, game_state, game_over
    );
    modport slave (
        input  frame_tick, start_btn, pacman_is_dead, food_eaten, pause_btn,
        output pacman_move_en, ghost_move_en, sprite_reload, score_clear,
               score_inc, lives, game_state, game_over
    );
`else
    modport master (
        output frame_tick, start_btn, pacman_is_dead, food_eaten,
        input  pacman_move_en, ghost_move_en, sprite_reload, score_clear,
               score_inc, lives, game_state, game_over
    );
    modport slave (
        input  frame_tick, start_btn, pacman_is_dead, food_eaten,
        output pacman_move_en, ghost_move_en, sprite_reload, score_clear,
               score_inc, lives, game_state, game_over
    );
`endif

endinterface

// File: rtl/game_round_sequencer_move_tick_gen.sv
// ---------------------------------------------------------------------------
// move_tick_gen
// Divides frame_tick by DIV and emits a registered 1-clk enable pulse on
// every DIV-th counted tick (first pulse on tick DIV after a clear).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : zero the divider count (takes priority over counting)
//   frame_tick  : tick to count
//   hold        : freeze the count and suppress pulses
//   en          : 1-clk enable pulse
// ---------------------------------------------------------------------------
module move_tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic frame_tick,
    input  logic hold,
    output logic en
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;
    logic          en_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            en_reg  <= 1'b0;
        end else if (clr) begin
            cnt_reg <= '0;
            en_reg  <= 1'b0;
        end else if (frame_tick && !hold) begin
            if (cnt_reg == LAST) begin
                cnt_reg <= '0;
                en_reg  <= 1'b1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
                en_reg  <= 1'b0;
            end
        end else begin
            en_reg <= 1'b0;
        end
    end

    assign en = en_reg;

endmodule

// File: rtl/game_round_sequencer.sv
// ---------------------------------------------------------------------------
// game_round_sequencer
// Top-level game controller: idle/attract, ready countdown, play, death
// freeze, respawn, level clear and game over. Gates sprite movement through
// per-frame move enables, commands sprite reloads, drives score clear/inc
// and tracks lives and eaten food. All outputs are registered.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : game_round_sequencer_if.slave (events in, controls out)
// Optional feature macro: GAME_SEQ_PAUSE_EN adds pause_btn and the PAUSE
// state (pause rise in PLAY toggles PLAY <-> PAUSE).
// ---------------------------------------------------------------------------
module game_round_sequencer
    import game_seq_pkg::*;
#(
    parameter int LIVES_INIT      = 3,
    parameter int LIVES_W         = 2,
    parameter int READY_TICKS     = 120,
    parameter int FREEZE_TICKS    = 90,
    parameter int PACMAN_MOVE_DIV = 2,
    parameter int GHOST_MOVE_DIV  = 3,
    parameter int FOOD_TOTAL      = 300,
    parameter int FOOD_W          = 10
) (
    input logic                   clk,
    input logic                   rst_n,
    game_round_sequencer_if.slave bus
);
    localparam int CNT_MAX = (READY_TICKS > FREEZE_TICKS) ? READY_TICKS : FREEZE_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]   READY_LAST  = CNT_W'(READY_TICKS - 1);
    localparam logic [CNT_W-1:0]   FREEZE_LAST = CNT_W'(FREEZE_TICKS - 1);
    localparam logic [FOOD_W-1:0]  FOOD_LAST   = FOOD_W'(FOOD_TOTAL);
    localparam logic [LIVES_W-1:0] LIVES_LOAD  = LIVES_W'(LIVES_INIT);

    game_state_t        state_reg, state_next;
    logic [CNT_W-1:0]   frame_cnt_reg, frame_cnt_next;
    logic [LIVES_W-1:0] lives_reg, lives_next;
    logic [FOOD_W-1:0]  food_cnt_reg, food_cnt_next;
    logic               start_prev_reg;
    logic               score_clear_reg, score_clear_next;
    logic               score_inc_reg, score_inc_next;
    logic               sprite_reload_reg, sprite_reload_next;
    logic               game_over_reg;
    logic               start_rise;
    logic               pause_rise;
    logic               move_clr;
    logic               move_hold;
    logic [1:0]         move_en;

    // Previous-level registers reset high so a button held through reset
    // has to be released and pressed again to count as an edge.
    assign start_rise = bus.start_btn && !start_prev_reg;

`ifdef GAME_SEQ_PAUSE_EN
    logic pause_prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_prev_reg <= 1'b1;
        end else begin
            pause_prev_reg <= bus.pause_btn;
        end
    end

    assign pause_rise = bus.pause_btn && !pause_prev_reg;
`else
    assign pause_rise = 1'b0;
`endif

    always_comb begin
        state_next       = state_reg;
        frame_cnt_next   = frame_cnt_reg;
        lives_next       = lives_reg;
        food_cnt_next    = food_cnt_reg;
        score_clear_next = 1'b0;
        score_inc_next   = 1'b0;

        case (state_reg)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_rise) begin
                    state_next       = ST_READY;
                    score_clear_next = 1'b1;
                    lives_next       = LIVES_LOAD;
                    food_cnt_next    = '0;
                end
            end
            ST_READY: begin
                if (bus.frame_tick) begin
                    if (frame_cnt_reg == READY_LAST) begin
                        state_next = ST_PLAY;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                // Death wins over a pellet in the same cycle; that pellet is lost.
                if (bus.pacman_is_dead) begin
                    state_next = ST_DYING;
                    lives_next = (lives_reg == '0) ? '0 : lives_reg - 1'b1;
                end else begin
                    if (bus.food_eaten) begin
                        score_inc_next = 1'b1;
                        food_cnt_next  = food_cnt_reg + 1'b1;
                        if (food_cnt_next == FOOD_LAST) begin
                            state_next = ST_LEVEL_CLEAR;
                        end
                    end
`ifdef GAME_SEQ_PAUSE_EN
                    if (pause_rise && state_next == ST_PLAY) begin
                        state_next = ST_PAUSE;
                    end
`endif
                end
            end
            ST_DYING: begin
                if (bus.frame_tick) begin
                    if (frame_cnt_reg == FREEZE_LAST) begin
                        state_next = (lives_reg == '0) ? ST_GAME_OVER : ST_RESPAWN;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + 1'b1;
                    end
                end
            end
            ST_RESPAWN: begin
                state_next = ST_READY;
            end
            ST_LEVEL_CLEAR: begin
                if (bus.frame_tick) begin
                    if (frame_cnt_reg == FREEZE_LAST) begin
                        state_next    = ST_READY;
                        food_cnt_next = '0;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + 1'b1;
                    end
                end
            end
`ifdef GAME_SEQ_PAUSE_EN
            ST_PAUSE: begin
                if (pause_rise) begin
                    state_next = ST_PLAY;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Every state starts its frame count from zero; a tick on the
        // transition edge belongs to the state being left.
        if (state_next != state_reg) begin
            frame_cnt_next = '0;
        end
    end

    // Sprites sit at their start positions in every state that is not
    // live gameplay or the death freeze.
    always_comb begin
        case (state_next)
            ST_PLAY, ST_DYING: sprite_reload_next = 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
            ST_PAUSE:          sprite_reload_next = 1'b0;
`endif
            default:           sprite_reload_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_IDLE;
            frame_cnt_reg     <= '0;
            lives_reg         <= LIVES_LOAD;
            food_cnt_reg      <= '0;
            start_prev_reg    <= 1'b1;
            score_clear_reg   <= 1'b0;
            score_inc_reg     <= 1'b0;
            sprite_reload_reg <= 1'b1;
            game_over_reg     <= 1'b0;
        end else begin
            state_reg         <= state_next;
            frame_cnt_reg     <= frame_cnt_next;
            lives_reg         <= lives_next;
            food_cnt_reg      <= food_cnt_next;
            start_prev_reg    <= bus.start_btn;
            score_clear_reg   <= score_clear_next;
            score_inc_reg     <= score_inc_next;
            sprite_reload_reg <= sprite_reload_next;
            game_over_reg     <= (state_next == ST_GAME_OVER);
        end
    end

    // Dividers restart in READY, count only on ticks where play continues
    // (so a tick on the edge leaving PLAY produces no stray enable), and
    // keep their phase through PAUSE.
    assign move_clr  = (state_reg == ST_READY);
    assign move_hold = !((state_reg == ST_PLAY) && (state_next == ST_PLAY));

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_move
            localparam int DIV_SEL = (gi == 0) ? PACMAN_MOVE_DIV : GHOST_MOVE_DIV;
            move_tick_gen #(
                .DIV(DIV_SEL)
            ) u_move_tick_gen (
                .clk       (clk),
                .rst_n     (rst_n),
                .clr       (move_clr),
                .frame_tick(bus.frame_tick),
                .hold      (move_hold),
                .en        (move_en[gi])
            );
        end
    endgenerate

    assign bus.pacman_move_en = move_en[0];
    assign bus.ghost_move_en  = move_en[1];
    assign bus.sprite_reload  = sprite_reload_reg;
    assign bus.score_clear    = score_clear_reg;
    assign bus.score_inc      = score_inc_reg;
    assign bus.lives          = lives_reg;
    assign bus.game_state     = state_reg;
    assign bus.game_over      = game_over_reg;

endmodule

// File: tb/tb_game_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_round_sequencer
// Directed bench for game_round_sequencer, built with FOOD_TOTAL=4 so a level
// can be cleared quickly; all other parameters at their defaults.
// Optional feature macro: GAME_SEQ_PAUSE_EN enables the pause steps.
// ---------------------------------------------------------------------------
module tb_game_round_sequencer;
    import game_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    game_round_sequencer_if #(.LIVES_W(2)) bus ();

    game_round_sequencer #(
        .FOOD_TOTAL(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int pm_cnt   = 0;
    int gh_cnt   = 0;
    int inc_cnt  = 0;
    int clr_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        $display("check %-14s observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one clock and tally the single-cycle output pulses.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.pacman_move_en === 1'b1) pm_cnt++;
        if (bus.ghost_move_en === 1'b1)  gh_cnt++;
        if (bus.score_inc === 1'b1)      inc_cnt++;
        if (bus.score_clear === 1'b1)    clr_cnt++;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            step();
            bus.frame_tick = 1'b0;
            step();
            step();
        end
    endtask

    task automatic eat();
        bus.food_eaten = 1'b1;
        step();
        bus.food_eaten = 1'b0;
        step();
    endtask

    task automatic die();
        bus.pacman_is_dead = 1'b1;
        step();
        bus.pacman_is_dead = 1'b0;
        step();
    endtask

    task automatic press_start();
        bus.start_btn = 1'b0;
        step();
        bus.start_btn = 1'b1;
        step();
    endtask

`ifdef GAME_SEQ_PAUSE_EN
    task automatic press_pause();
        bus.pause_btn = 1'b1;
        step();
        bus.pause_btn = 1'b0;
        step();
    endtask
`endif

    // Last tick of a death freeze: observe the single RESPAWN clock, then READY.
    task automatic respawn_exit();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        chk("respawn_state", bus.game_state, ST_RESPAWN);
        chk("respawn_reload", bus.sprite_reload, 1);
        step();
        chk("respawn_ready", bus.game_state, ST_READY);
    endtask

    initial begin
        bus.frame_tick     = 1'b0;
        bus.start_btn      = 1'b1;
        bus.pacman_is_dead = 1'b0;
        bus.food_eaten     = 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
        bus.pause_btn      = 1'b0;
`endif

        // Reset with start held high
        repeat (3) step();
        chk("rst_state", bus.game_state, ST_IDLE);
        chk("rst_lives", bus.lives, 3);
        chk("rst_reload", bus.sprite_reload, 1);
        chk("rst_game_over", bus.game_over, 0);
        chk("rst_score_clr", bus.score_clear, 0);
        rst_n = 1'b1;
        repeat (3) step();
        chk("held_start", bus.game_state, ST_IDLE);

        // Start: score_clear one clock, READY for 120 ticks
        clr_cnt = 0;
        press_start();
        chk("start_clr", bus.score_clear, 1);
        chk("start_state", bus.game_state, ST_READY);
        chk("start_lives", bus.lives, 3);
        step();
        chk("clr_pulses", clr_cnt, 1);
        frames(119);
        chk("ready_119", bus.game_state, ST_READY);
        chk("ready_reload", bus.sprite_reload, 1);
        frames(1);
        chk("ready_120", bus.game_state, ST_PLAY);
        chk("play_reload", bus.sprite_reload, 0);

        // Move dividers: pacman on ticks 2,4,6; ghost on 3,6
        pm_cnt = 0;
        gh_cnt = 0;
        frames(2);
        chk("pm_t2", pm_cnt, 1);
        chk("gh_t2", gh_cnt, 0);
        frames(1);
        chk("pm_t3", pm_cnt, 1);
        chk("gh_t3", gh_cnt, 1);
        frames(3);
        chk("pm_t6", pm_cnt, 3);
        chk("gh_t6", gh_cnt, 2);

`ifdef GAME_SEQ_PAUSE_EN
        pm_cnt = 0;
        gh_cnt = 0;
        frames(1);
        press_pause();
        chk("pause_state", bus.game_state, ST_PAUSE);
        frames(10);
        chk("pause_pm", pm_cnt, 0);
        chk("pause_gh", gh_cnt, 0);
        press_pause();
        chk("resume_state", bus.game_state, ST_PLAY);
        frames(1);
        chk("resume_pm", pm_cnt, 1);
        chk("resume_gh", gh_cnt, 0);
        frames(1);
        chk("resume_gh2", gh_cnt, 1);
`endif

        // Food in PLAY, then first death
        inc_cnt = 0;
        eat();
        chk("food1_inc", inc_cnt, 1);
        die();
        chk("death1_state", bus.game_state, ST_DYING);
        chk("death1_lives", bus.lives, 2);
        eat();
        chk("dying_food", inc_cnt, 1);
        frames(89);
        chk("dying_89", bus.game_state, ST_DYING);
        respawn_exit();
        frames(120);
        chk("play2", bus.game_state, ST_PLAY);

        // Death and food in the same clock: food dropped
        bus.food_eaten     = 1'b1;
        bus.pacman_is_dead = 1'b1;
        step();
        bus.food_eaten     = 1'b0;
        bus.pacman_is_dead = 1'b0;
        step();
        chk("combo_state", bus.game_state, ST_DYING);
        chk("combo_lives", bus.lives, 1);
        chk("combo_inc", inc_cnt, 1);
        frames(89);
        respawn_exit();
        frames(120);

        // food_cnt still 1: three more pellets clear the level
        eat();
        eat();
        chk("food3_state", bus.game_state, ST_PLAY);
        eat();
        chk("food4_inc", inc_cnt, 4);
        chk("clear_state", bus.game_state, ST_LEVEL_CLEAR);
        chk("clear_reload", bus.sprite_reload, 1);
        frames(89);
        chk("clear_89", bus.game_state, ST_LEVEL_CLEAR);
        frames(1);
        chk("clear_exit", bus.game_state, ST_READY);
        chk("clear_lives", bus.lives, 1);
        frames(120);

        // food_cnt restarted at 0: three pellets keep play going
        eat();
        eat();
        eat();
        chk("lvl2_state", bus.game_state, ST_PLAY);
        chk("lvl2_inc", inc_cnt, 7);

        // Last life
        die();
        chk("death3_lives", bus.lives, 0);
        frames(90);
        chk("go_state", bus.game_state, ST_GAME_OVER);
        chk("go_flag", bus.game_over, 1);
        chk("go_reload", bus.sprite_reload, 1);
        eat();
        die();
        chk("go_inc", inc_cnt, 7);
        chk("go_lives", bus.lives, 0);

        // Restart from GAME_OVER
        clr_cnt = 0;
        press_start();
        chk("restart_state", bus.game_state, ST_READY);
        chk("restart_lives", bus.lives, 3);
        chk("restart_clr", bus.score_clear, 1);
        chk("restart_go", bus.game_over, 0);
        frames(5);

        // Asynchronous reset mid-game, start still held
        rst_n = 1'b0;
        #1;
        chk("arst_state", bus.game_state, ST_IDLE);
        chk("arst_reload", bus.sprite_reload, 1);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("arst_idle", bus.game_state, ST_IDLE);
        chk("arst_clr", clr_cnt, 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
